// File: rtl/spmv_pkg.sv
// Shared constants for the SpMV per-kernel run controller: FSM encoding,
// ctrl/status bit positions and the config/status slice width.
package spmv_pkg;

  localparam int SLICE_W = 96;

  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ABORTED_BIT = 2;
  localparam int STAT_ROW_OVF_BIT = 3;
  localparam int STAT_TIMEOUT_BIT = 4;
  localparam int STAT_ZERO_BIT    = 5;
  localparam int STAT_ROW_LSB     = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/spmv_start_edge.sv
// Start rising-edge detector; a start is accepted only while the kernel is
// idle or finished, so edges seen during a run are dropped, not queued.
module spmv_start_edge
  import spmv_pkg::*;
(
  input  logic   aclk,
  input  logic   aresetn,
  input  logic   start_lvl,
  input  state_t state,
  output logic   start_accept
);

  logic start_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) start_q <= 1'b0;
    else          start_q <= start_lvl;
  end

  assign start_accept = start_lvl & ~start_q & ((state == S_IDLE) || (state == S_DONE));

endmodule

// File: rtl/spmv_kernel_ctrl.sv
// Per-kernel SpMV run controller: gates the nnz stream, counts result rows and
// cycles, and reports a 96-bit status slice. Optional run timeout: SPMV_KERNEL_TIMEOUT_EN.
module spmv_kernel_ctrl
  import spmv_pkg::*;
#(
  parameter int          CNT_W          = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
)(
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [SLICE_W-1:0] config_in,
  output logic [SLICE_W-1:0] status_out,
  input  logic               s_nnz_valid,
  output logic               s_nnz_ready,
  output logic               m_nnz_valid,
  input  logic               m_nnz_ready,
  output logic               eng_start,
  output logic [31:0]        eng_row_num,
  output logic [31:0]        eng_nnz_num,
  input  logic               row_done_valid,
  input  logic               row_done_ready
);

  state_t           state, state_nx;
  logic [31:0]      row_tgt, row_tgt_nx, nnz_tgt, nnz_tgt_nx;
  logic [31:0]      row_cnt, row_cnt_nx, nnz_cnt, nnz_cnt_nx;
  logic [CNT_W-1:0] cyc_cnt, cyc_nx;
  logic             aborted, aborted_nx, row_ovf, row_ovf_nx;
  logic             timeout, timeout_nx, zero_cfg, zero_cfg_nx;
  logic             eng_start_nx, cfg_zero;
  logic [31:0]      status_word_nx;
  logic             start_accept, abort_req, gate, nnz_hs, row_hs, complete, tmo_hit;
  logic             ctrl_unused;

  spmv_start_edge u_start_edge (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start_lvl    (config_in[START_BIT]),
    .state        (state),
    .start_accept (start_accept)
  );

  assign ctrl_unused = ^config_in[31:2];
  assign abort_req   = config_in[ABORT_BIT];
  assign cfg_zero    = (config_in[63:32] == 32'd0) || (config_in[95:64] == 32'd0);

  // Abort shuts the gate in the same cycle it is seen, before the state moves.
  assign gate        = (state == S_RUN) && (nnz_cnt < nnz_tgt) && !abort_req;
  assign m_nnz_valid = s_nnz_valid & gate;
  assign s_nnz_ready = m_nnz_ready & gate;
  assign nnz_hs      = m_nnz_valid & m_nnz_ready;
  assign row_hs      = row_done_valid & row_done_ready & (state == S_RUN);
  assign complete    = (state == S_RUN) && (nnz_cnt == nnz_tgt) && (row_cnt == row_tgt);

`ifdef SPMV_KERNEL_TIMEOUT_EN
  assign tmo_hit = (state == S_RUN) && ((cyc_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
`else
  logic tmo_unused;
  assign tmo_unused = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    row_tgt_nx   = row_tgt;
    nnz_tgt_nx   = nnz_tgt;
    row_cnt_nx   = row_cnt;
    nnz_cnt_nx   = nnz_cnt;
    cyc_nx       = cyc_cnt;
    aborted_nx   = aborted;
    row_ovf_nx   = row_ovf;
    timeout_nx   = timeout;
    zero_cfg_nx  = zero_cfg;
    eng_start_nx = 1'b0;
    if (start_accept) begin
      row_tgt_nx   = config_in[63:32];
      nnz_tgt_nx   = config_in[95:64];
      row_cnt_nx   = '0;
      nnz_cnt_nx   = '0;
      cyc_nx       = '0;
      aborted_nx   = 1'b0;
      row_ovf_nx   = 1'b0;
      timeout_nx   = 1'b0;
      zero_cfg_nx  = cfg_zero;
      state_nx     = cfg_zero ? S_DONE : S_RUN;
      eng_start_nx = !cfg_zero;
    end else if (state == S_RUN) begin
      cyc_nx = cyc_cnt + CNT_W'(1);
      if (nnz_hs) nnz_cnt_nx = nnz_cnt + 32'd1;
      if (row_hs) begin
        if (row_cnt == row_tgt) row_ovf_nx = 1'b1;
        else                    row_cnt_nx = row_cnt + 32'd1;
      end
      // Completion outranks timeout, which outranks abort.
      if (complete) begin
        state_nx = S_DONE;
      end else if (tmo_hit) begin
        state_nx   = S_DONE;
        timeout_nx = 1'b1;
      end else if (abort_req) begin
        state_nx   = S_DONE;
        aborted_nx = 1'b1;
      end
    end
    status_word_nx                              = '0;
    status_word_nx[STAT_BUSY_BIT]               = (state_nx == S_RUN);
    status_word_nx[STAT_DONE_BIT]               = (state_nx == S_DONE);
    status_word_nx[STAT_ABORTED_BIT]            = aborted_nx;
    status_word_nx[STAT_ROW_OVF_BIT]            = row_ovf_nx;
    status_word_nx[STAT_TIMEOUT_BIT]            = timeout_nx;
    status_word_nx[STAT_ZERO_BIT]               = zero_cfg_nx;
    status_word_nx[STAT_ROW_LSB+15:STAT_ROW_LSB] = row_cnt_nx[15:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      row_tgt    <= '0;
      nnz_tgt    <= '0;
      row_cnt    <= '0;
      nnz_cnt    <= '0;
      cyc_cnt    <= '0;
      aborted    <= 1'b0;
      row_ovf    <= 1'b0;
      timeout    <= 1'b0;
      zero_cfg   <= 1'b0;
      eng_start  <= 1'b0;
      status_out <= '0;
    end else begin
      state      <= state_nx;
      row_tgt    <= row_tgt_nx;
      nnz_tgt    <= nnz_tgt_nx;
      row_cnt    <= row_cnt_nx;
      nnz_cnt    <= nnz_cnt_nx;
      cyc_cnt    <= cyc_nx;
      aborted    <= aborted_nx;
      row_ovf    <= row_ovf_nx;
      timeout    <= timeout_nx;
      zero_cfg   <= zero_cfg_nx;
      eng_start  <= eng_start_nx;
      status_out <= {status_word_nx, cyc_nx};
    end
  end

  assign eng_row_num = row_tgt;
  assign eng_nnz_num = nnz_tgt;

endmodule
